// File: rtl/mem_wb_stage.sv
// Memory/write-back pipeline register with write-back mux and decode-stage hazard detection.
// Optional retired-instruction counter is built when MEM_WB_RETIRE_CNT_EN is defined.
module mem_wb_stage #(
    parameter int REG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              valid_in,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] mem_result_in,
    input  logic [REG_W-1:0]  dest_in,
    input  logic [REG_W-1:0]  src1,
    input  logic [REG_W-1:0]  src2,
    output logic              wb_en,
    output logic [REG_W-1:0]  wb_dest,
    output logic [DATA_W-1:0] wb_value,
    output logic              hz_src1,
    output logic              hz_src2
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    output logic [31:0]       retire_count
`endif
);

    logic              r_valid;
    logic              r_wb_en;
    logic              r_mem_r_en;
    logic [DATA_W-1:0] r_alu_result;
    logic [DATA_W-1:0] r_mem_result;
    logic [REG_W-1:0]  r_dest;

    logic              w_capture;
    logic              w_wb_en;

    assign w_capture = ~flush & ~freeze;

    // Pipeline registers: flush bubbles the entry but keeps its data, freeze holds everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid      <= 1'b0;
            r_wb_en      <= 1'b0;
            r_mem_r_en   <= 1'b0;
            r_alu_result <= {DATA_W{1'b0}};
            r_mem_result <= {DATA_W{1'b0}};
            r_dest       <= {REG_W{1'b0}};
        end else if (flush) begin
            r_valid <= 1'b0;
            r_wb_en <= 1'b0;
        end else if (!freeze) begin
            r_valid      <= valid_in;
            r_wb_en      <= wb_en_in;
            r_mem_r_en   <= mem_r_en_in;
            r_alu_result <= alu_result_in;
            r_mem_result <= mem_result_in;
            r_dest       <= dest_in;
        end else begin
            r_valid      <= r_valid;
            r_wb_en      <= r_wb_en;
            r_mem_r_en   <= r_mem_r_en;
            r_alu_result <= r_alu_result;
            r_mem_result <= r_mem_result;
            r_dest       <= r_dest;
        end
    end

    // Write-back port and hazard flags are decoded straight from the stage registers.
    always_comb begin
        w_wb_en  = r_wb_en & r_valid;
        wb_en    = w_wb_en;
        wb_dest  = r_dest;
        wb_value = r_alu_result;
        if (r_mem_r_en) begin
            wb_value = r_mem_result;
        end else begin
            wb_value = r_alu_result;
        end
        hz_src1 = w_wb_en & (r_dest == src1);
        hz_src2 = w_wb_en & (r_dest == src2);
    end

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [31:0] r_retire_count;

    // An instruction retires when a valid entry is overwritten by a capture; wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retire_count <= 32'd0;
        end else if (w_capture && r_valid) begin
            r_retire_count <= r_retire_count + 32'd1;
        end else begin
            r_retire_count <= r_retire_count;
        end
    end

    assign retire_count = r_retire_count;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed plus randomized bench for mem_wb_stage against a behavioural stage model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic        valid_in;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic [31:0] alu_result_in;
    logic [31:0] mem_result_in;
    logic [3:0]  dest_in;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic        hz_src1;
    logic        hz_src2;
`ifdef MEM_WB_RETIRE_CNT_EN
    logic [31:0] retire_count;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: one entry of the stage as plain variables.
    logic        m_valid, m_wb, m_mr;
    logic [31:0] m_alu, m_mem;
    logic [3:0]  m_dest;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    mem_wb_stage #(.REG_W(4), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .flush         (flush),
        .valid_in      (valid_in),
        .wb_en_in      (wb_en_in),
        .mem_r_en_in   (mem_r_en_in),
        .alu_result_in (alu_result_in),
        .mem_result_in (mem_result_in),
        .dest_in       (dest_in),
        .src1          (src1),
        .src2          (src2),
        .wb_en         (wb_en),
        .wb_dest       (wb_dest),
        .wb_value      (wb_value),
        .hz_src1       (hz_src1),
        .hz_src2       (hz_src2)
`ifdef MEM_WB_RETIRE_CNT_EN
        ,
        .retire_count  (retire_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_valid = 1'b0; m_wb = 1'b0; m_mr = 1'b0;
        m_alu = 32'd0; m_mem = 32'd0; m_dest = 4'd0; m_cnt = 32'd0;
    endtask

    task automatic check_model(input string ctx);
        logic        e_wb;
        logic [31:0] e_val;
        e_wb  = m_valid && m_wb;
        e_val = m_mr ? m_mem : m_alu;
        check({ctx, ".wb_en"},    {31'd0, wb_en},    {31'd0, e_wb});
        check({ctx, ".wb_dest"},  {28'd0, wb_dest},  {28'd0, m_dest});
        check({ctx, ".wb_value"}, wb_value,          e_val);
        check({ctx, ".hz_src1"},  {31'd0, hz_src1},  {31'd0, e_wb && (m_dest == src1)});
        check({ctx, ".hz_src2"},  {31'd0, hz_src2},  {31'd0, e_wb && (m_dest == src2)});
`ifdef MEM_WB_RETIRE_CNT_EN
        check({ctx, ".retire_count"}, retire_count, m_cnt);
`endif
    endtask

    // One clock: the model absorbs the inputs seen at the edge, then outputs are checked 1ns later.
    task automatic step(input string ctx);
        @(posedge clk);
        if (rst) begin
            if (flush) begin
                m_valid = 1'b0;
                m_wb    = 1'b0;
            end else if (!freeze) begin
                if (m_valid) m_cnt = m_cnt + 32'd1;
                m_valid = valid_in; m_wb = wb_en_in; m_mr = mem_r_en_in;
                m_alu = alu_result_in; m_mem = mem_result_in; m_dest = dest_in;
            end
        end
        #1;
        check_model(ctx);
    endtask

    task automatic drive_random();
        valid_in      = 1'($urandom);
        wb_en_in      = 1'($urandom);
        mem_r_en_in   = 1'($urandom);
        alu_result_in = $urandom;
        mem_result_in = $urandom;
        dest_in       = 4'($urandom);
        src1          = 4'($urandom);
        src2          = ($urandom_range(0, 3) == 0) ? src1 : 4'($urandom);
    endtask

    initial begin
        model_clear();
        rst = 1'b0; freeze = 1'b0; flush = 1'b0;
        src1 = 4'd3; src2 = 4'd3;
        valid_in = 1'b1; wb_en_in = 1'b1; mem_r_en_in = 1'b1;
        alu_result_in = 32'h0000_0400; mem_result_in = 32'hDEAD_BEEF; dest_in = 4'd3;

        #2;
        check_model("reset_t0");
        @(posedge clk); #1;
        check_model("reset_edge_held");
        #4 rst = 1'b1;

        step("load");
        check("load.wb_en_const",    {31'd0, wb_en}, 32'd1);
        check("load.wb_dest_const",  {28'd0, wb_dest}, 32'd3);
        check("load.wb_value_const", wb_value, 32'hDEAD_BEEF);

        mem_r_en_in = 1'b0; alu_result_in = 32'h1234_5678; dest_in = 4'd7;
        src1 = 4'd7; src2 = 4'd2;
        step("alu");
        check("alu.wb_value_const", wb_value, 32'h1234_5678);
        check("alu.hz_src1_const",  {31'd0, hz_src1}, 32'd1);
        check("alu.hz_src2_const",  {31'd0, hz_src2}, 32'd0);

        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            step("freeze");
            check("freeze.wb_value_const", wb_value, 32'h1234_5678);
            check("freeze.wb_dest_const",  {28'd0, wb_dest}, 32'd7);
            check("freeze.wb_en_const",    {31'd0, wb_en}, 32'd1);
        end
        flush = 1'b1;
        step("flush_freeze");
        check("flush_freeze.wb_en_const", {31'd0, wb_en}, 32'd0);
        check("flush_freeze.data_kept",   wb_value, 32'h1234_5678);

        flush = 1'b0; freeze = 1'b0;
        valid_in = 1'b1; wb_en_in = 1'b1; mem_r_en_in = 1'b0;
        alu_result_in = 32'hCAFE_0001; dest_in = 4'd9;
        step("pre_reset_load");
        check("pre_reset.wb_en_const", {31'd0, wb_en}, 32'd1);
        freeze = 1'b1;
        #3 rst = 1'b0;
        #1;
        model_clear();
        check_model("async_reset");
        check("async_reset.wb_en_const",    {31'd0, wb_en}, 32'd0);
        check("async_reset.wb_value_const", wb_value, 32'd0);
        #1 rst = 1'b1;
        freeze = 1'b0;
        step("post_reset_capture");
        check("post_reset.wb_value_const", wb_value, 32'hCAFE_0001);

        for (int i = 0; i < 300; i++) begin
            drive_random();
            freeze = ($urandom_range(0, 3) == 0);
            flush  = ($urandom_range(0, 7) == 0);
            step("random");
        end

`ifdef MEM_WB_RETIRE_CNT_EN
        freeze = 1'b0; flush = 1'b0;
        valid_in = 1'b1; wb_en_in = 1'b1;
        step("retire_prep");
        #2;
        dut.r_retire_count = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        step("retire_1");
        check("retire_1.const", retire_count, 32'hFFFF_FFFF);
        step("retire_2");
        check("retire_2.const", retire_count, 32'h0000_0000);
        step("retire_3");
        check("retire_3.const", retire_count, 32'h0000_0001);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter: REG_W, 4, destination register index width.
REQ-002 Parameter: DATA_W, 32, data path width.
REQ-003 Port: clk  input  1  rising-edge clock, the only clock.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: freeze  input  1  hold all pipeline registers for this cycle.
REQ-006 Port: flush  input  1  bubble-insert: clear valid and write-enable for this cycle.
REQ-007 Port: valid_in  input  1  memory-access stage holds a real instruction.
REQ-008 Port: wb_en_in  input  1  instruction writes the register file.
REQ-009 Port: mem_r_en_in  input  1  instruction is a load; result comes from memory.
REQ-010 Port: alu_result_in  input  DATA_W  ALU result / effective address from upstream.
REQ-011 Port: mem_result_in  input  DATA_W  load data from the memory-access stage.
REQ-012 Port: dest_in  input  REG_W  destination register index.
REQ-013 Port: src1, src2  input  REG_W  decode-stage source indices for hazard check.
REQ-014 Port: wb_en  output  1  register-file write strobe.
REQ-015 Port: wb_dest  output  REG_W  register-file write index.
REQ-016 Port: wb_value  output  DATA_W  register-file write data.
REQ-017 Port: hz_src1, hz_src2  output  1  pending write-back matches src1 / src2.
REQ-018 Port: retire_count  output  32  retired-instruction count; present only with RETIRE_CNT_EN.

Function
REQ-019 The block SHALL hold registered copies of valid, wb_en, mem_r_en, alu_result, mem_result and dest.
REQ-020 On a rising clk edge with flush=1, the block SHALL clear valid_q and wb_en_q and leave the data registers unchanged.
REQ-021 flush SHALL take priority over freeze when both are 1 on the same edge.
REQ-022 On a rising clk edge with flush=0 and freeze=1, the block SHALL hold every register unchanged.
REQ-023 On a rising clk edge with flush=0 and freeze=0, the block SHALL capture all inputs; latency is exactly one cycle.
REQ-024 wb_en SHALL equal wb_en_q AND valid_q, so an invalid entry never writes.
REQ-025 wb_value SHALL equal mem_result_q when mem_r_en_q=1, otherwise alu_result_q; this is combinational from the registers.
REQ-026 wb_dest SHALL equal dest_q.
REQ-027 hz_srcN SHALL be 1 iff wb_en=1 and dest_q equals srcN; both outputs may assert in the same cycle.
REQ-028 A freeze held for N cycles SHALL present the same wb_en, wb_dest and wb_value for all N cycles.

Reset
REQ-029 When rst=0, the block SHALL immediately clear every register to 0, independent of clk; wb_en, wb_dest, wb_value, hz_src1, hz_src2 and retire_count then read 0.
REQ-030 Reset asserted mid-freeze or mid-flush SHALL override both; after rst rises, the first capture SHALL occur on the next qualifying edge.

Configuration
REQ-031 With macro MEM_WB_RETIRE_CNT_EN defined, the block SHALL include a 32-bit retire_count register and port.
REQ-032 retire_count SHALL increment by 1 on each edge where wb_en=1 or valid_q=1 is being replaced by a capture (flush=0, freeze=0), counting each valid_q instruction exactly once as it leaves the stage.
REQ-033 retire_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-034 Without MEM_WB_RETIRE_CNT_EN, the retire_count port and its register SHALL be absent; all other behaviour is identical.

Verification
REQ-035 Load: valid_in=1, wb_en_in=1, mem_r_en_in=1, alu_result_in=0x400, mem_result_in=0xDEADBEEF, dest_in=3 -> next cycle wb_en=1, wb_dest=3, wb_value=0xDEADBEEF.
REQ-036 ALU op: mem_r_en_in=0, alu_result_in=0x12345678, dest_in=7 -> next cycle wb_value=0x12345678; with src1=7, src2=2: hz_src1=1, hz_src2=0.
REQ-037 freeze=1 for 3 cycles with changing inputs -> outputs stay at the pre-freeze values; flush=1 together with freeze=1 -> wb_en=0 on the next cycle.
REQ-038 rst pulled low between clock edges while wb_en=1 -> wb_en, wb_value and retire_count read 0 before the next edge.
REQ-039 With MEM_WB_RETIRE_CNT_EN: preload retire_count to 0xFFFFFFFE, then retire 3 valid instructions -> count reads 0xFFFFFFFF, 0, 1.
